// File: rtl/dmac_pkg.sv
// Shared definitions for the DMA control-port arbiter slice.
package dmac_pkg;

    // Default depth of the response route FIFO (outstanding transactions).
    localparam int MAX_OUTSTND_DEF = 4;

    // Width of a port index; a single port still needs one bit to index it.
    function automatic int port_idx_w(input int nb_ports);
        return (nb_ports > 1) ? $clog2(nb_ports) : 1;
    endfunction

endpackage

// File: rtl/dmac_route_fifo.sv
// Route FIFO: remembers which slave port owns each granted-but-unanswered
// transaction so in-order responses can be steered back to it.
module dmac_route_fifo
    import dmac_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTND_DEF,
    parameter int WIDTH = 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Overflow/underflow are refused here so the FIFO state can never corrupt.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; entries are only read after being written.
    // NOTE: memory is not reset -- the pointers/count define validity, and an unreset array maps to plain RAM.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/dmac_ctrl_arb.sv
// Round-robin arbiter merging NB_PORTS control slave ports onto one DMA
// control target, with in-order response routing back to the requester.
module dmac_ctrl_arb
    import dmac_pkg::*;
#(
    parameter int NB_PORTS    = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 5,
    parameter int MAX_OUTSTND = MAX_OUTSTND_DEF,
    localparam int BE_WIDTH   = DATA_WIDTH / 8,
    localparam int CNT_WIDTH  = $clog2(MAX_OUTSTND + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NB_PORTS-1:0]                 s_req_i,
    input  logic [NB_PORTS-1:0]                 s_wen_i,
    input  logic [NB_PORTS-1:0][ADDR_WIDTH-1:0] s_add_i,
    input  logic [NB_PORTS-1:0][DATA_WIDTH-1:0] s_wdata_i,
    input  logic [NB_PORTS-1:0][BE_WIDTH-1:0]   s_be_i,
    input  logic [NB_PORTS-1:0][ID_WIDTH-1:0]   s_id_i,
    output logic [NB_PORTS-1:0]                 s_gnt_o,
    output logic [NB_PORTS-1:0]                 s_r_valid_o,
    output logic [NB_PORTS-1:0][DATA_WIDTH-1:0] s_r_rdata_o,
    output logic [NB_PORTS-1:0][ID_WIDTH-1:0]   s_r_id_o,
    output logic                                m_req_o,
    output logic                                m_wen_o,
    output logic [ADDR_WIDTH-1:0]               m_add_o,
    output logic [DATA_WIDTH-1:0]               m_wdata_o,
    output logic [BE_WIDTH-1:0]                 m_be_o,
    output logic [ID_WIDTH-1:0]                 m_id_o,
    input  logic                                m_gnt_i,
    input  logic                                m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]               m_r_rdata_i,
    input  logic [ID_WIDTH-1:0]                 m_r_id_i,
    output logic [CNT_WIDTH-1:0]                outstnd_o,
    output logic                                err_o
);

    localparam int PW = port_idx_w(NB_PORTS);

    logic [PW-1:0] rr_q;
    logic [PW-1:0] winner;
    logic [PW-1:0] route_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          grant;
    logic          pop;
    logic          err_q;
    int            idx;
    logic          found;

    // Round-robin search: first requester at or after rr_q, wrapping modulo NB_PORTS.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NB_PORTS; i++) begin
            idx = (int'(rr_q) + i) % NB_PORTS;
            if (!found && s_req_i[PW'(idx)]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    // fifo_full is registered, so a same-cycle response cannot reopen the request path.
    assign m_req_o = (|s_req_i) && !fifo_full && !rst_i;
    assign grant   = m_req_o && m_gnt_i;
    assign pop     = m_r_valid_i && !fifo_empty && !rst_i;
    assign err_o   = err_q;

    // Forward the winner's payload with no added latency; zero when idle.
    always_comb begin
        m_wen_o   = 1'b0;
        m_add_o   = '0;
        m_wdata_o = '0;
        m_be_o    = '0;
        m_id_o    = '0;
        s_gnt_o   = '0;
        if (m_req_o) begin
            m_wen_o   = s_wen_i[winner];
            m_add_o   = s_add_i[winner];
            m_wdata_o = s_wdata_i[winner];
            m_be_o    = s_be_i[winner];
            m_id_o    = s_id_i[winner];
        end
        if (grant) s_gnt_o[winner] = 1'b1;
    end

    // Steer the in-order response to the port at the head of the route FIFO.
    always_comb begin
        s_r_valid_o = '0;
        s_r_rdata_o = '0;
        s_r_id_o    = '0;
        if (pop) begin
            s_r_valid_o[route_head] = 1'b1;
            s_r_rdata_o[route_head] = m_r_rdata_i;
            s_r_id_o[route_head]    = m_r_id_i;
        end
    end

    // Advance the round-robin pointer past each granted port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else if (grant) begin
            rr_q <= (winner == PW'(NB_PORTS - 1)) ? '0 : winner + PW'(1);
        end
    end

    // Sticky error: a response arrived with no transaction to route it to.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (m_r_valid_i && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    dmac_route_fifo #(
        .DEPTH (MAX_OUTSTND),
        .WIDTH (PW)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .pop_i   (pop),
        .din_i   (winner),
        .dout_o  (route_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstnd_o)
    );

endmodule

// File: tb/tb_dmac_ctrl_arb.sv
// Bench for dmac_ctrl_arb: directed scenarios plus randomized traffic against
// a queue-based reference model of arbitration and in-order response routing.
module tb_dmac_ctrl_arb;

    localparam int NB  = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IDW = 5;
    localparam int MO  = 4;
    localparam int BEW = DW / 8;
    localparam int PW  = 2;
    localparam int CW  = 3;
    localparam int PLW = 1 + AW + DW + BEW + IDW;

    logic                   clk;
    logic                   rst_i;
    logic [NB-1:0]          s_req_i, s_wen_i;
    logic [NB-1:0][AW-1:0]  s_add_i;
    logic [NB-1:0][DW-1:0]  s_wdata_i;
    logic [NB-1:0][BEW-1:0] s_be_i;
    logic [NB-1:0][IDW-1:0] s_id_i;
    logic [NB-1:0]          s_gnt_o, s_r_valid_o;
    logic [NB-1:0][DW-1:0]  s_r_rdata_o;
    logic [NB-1:0][IDW-1:0] s_r_id_o;
    logic                   m_req_o, m_wen_o;
    logic [AW-1:0]          m_add_o;
    logic [DW-1:0]          m_wdata_o;
    logic [BEW-1:0]         m_be_o;
    logic [IDW-1:0]         m_id_o;
    logic                   m_gnt_i, m_r_valid_i;
    logic [DW-1:0]          m_r_rdata_i;
    logic [IDW-1:0]         m_r_id_i;
    logic [CW-1:0]          outstnd_o;
    logic                   err_o;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: round-robin pointer, queue of owning ports, sticky error.
    int mdl_rr;
    int mdl_q[$];
    bit mdl_err;

    dmac_ctrl_arb #(
        .NB_PORTS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .MAX_OUTSTND(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_req_i(s_req_i), .s_wen_i(s_wen_i), .s_add_i(s_add_i), .s_wdata_i(s_wdata_i),
        .s_be_i(s_be_i), .s_id_i(s_id_i),
        .s_gnt_o(s_gnt_o), .s_r_valid_o(s_r_valid_o), .s_r_rdata_o(s_r_rdata_o), .s_r_id_o(s_r_id_o),
        .m_req_o(m_req_o), .m_wen_o(m_wen_o), .m_add_o(m_add_o), .m_wdata_o(m_wdata_o),
        .m_be_o(m_be_o), .m_id_o(m_id_o),
        .m_gnt_i(m_gnt_i), .m_r_valid_i(m_r_valid_i), .m_r_rdata_i(m_r_rdata_i), .m_r_id_i(m_r_id_i),
        .outstnd_o(outstnd_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] ix(input int p);
        return PW'(p);
    endfunction

    // Winning port under the model, or -1 when nothing may be requested.
    function automatic int mdl_winner();
        if (rst_i || mdl_q.size() >= MO) return -1;
        for (int i = 0; i < NB; i++) begin
            int p = (mdl_rr + i) % NB;
            if (s_req_i[ix(p)]) return p;
        end
        return -1;
    endfunction

    function automatic logic [PLW-1:0] mdl_payload(input int w);
        if (w < 0) return '0;
        return {s_wen_i[ix(w)], s_add_i[ix(w)], s_wdata_i[ix(w)], s_be_i[ix(w)], s_id_i[ix(w)]};
    endfunction

    function automatic void mdl_reset();
        mdl_rr  = 0;
        mdl_q.delete();
        mdl_err = 1'b0;
    endfunction

    // Apply the current inputs to the model as the clock edge would.
    function automatic void mdl_step();
        int w;
        if (rst_i) begin
            mdl_reset();
            return;
        end
        w = mdl_winner();
        if (m_r_valid_i) begin
            if (mdl_q.size() > 0) void'(mdl_q.pop_front());
            else mdl_err = 1'b1;
        end
        if (w >= 0 && m_gnt_i) begin
            mdl_q.push_back(w);
            mdl_rr = (w + 1) % NB;
        end
    endfunction

    task automatic drive_idle();
        s_req_i = '0; s_wen_i = '0; s_add_i = '0; s_wdata_i = '0; s_be_i = '0; s_id_i = '0;
        m_gnt_i = 1'b0; m_r_valid_i = 1'b0; m_r_rdata_i = '0; m_r_id_i = '0;
    endtask

    task automatic step();
        mdl_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        drive_idle();
        mdl_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive_idle();
        s_req_i = 3'b011; m_gnt_i = 1'b1; m_r_valid_i = 1'b1; m_r_rdata_i = 32'h1234_5678;
        @(negedge clk);
        n_total++; if (m_req_o !== 1'b0) $display("FAIL reset_m_req: got %b want 0", m_req_o); else n_pass++;
        n_total++; if (s_gnt_o !== 3'b000) $display("FAIL reset_gnt: got %b want 000", s_gnt_o); else n_pass++;
        n_total++; if (s_r_valid_o !== 3'b000) $display("FAIL reset_rvalid: got %b want 000", s_r_valid_o); else n_pass++;
        n_total++; if (outstnd_o !== 3'd0) $display("FAIL reset_outstnd: got %0d want 0", outstnd_o); else n_pass++;
        n_total++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else n_pass++;
        mdl_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        drive_idle();
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_idle();
            s_req_i = 3'b011; m_gnt_i = 1'b1;
            m_r_valid_i = (i > 0); m_r_rdata_i = $urandom;
            @(negedge clk);
            n_total++;
            if (s_gnt_o !== 3'(1 << (i % 2)))
                $display("FAIL rr_grant[%0d]: got %b want %b", i, s_gnt_o, 3'(1 << (i % 2)));
            else n_pass++;
            n_total++;
            if (s_r_valid_o !== ((i > 0) ? 3'(1 << ((i - 1) % 2)) : 3'b000))
                $display("FAIL rr_route[%0d]: got %b", i, s_r_valid_o);
            else n_pass++;
            step();
        end
        drive_idle();
        m_r_valid_i = 1'b1;
        @(negedge clk);
        n_total++; if (s_r_valid_o !== 3'b010) $display("FAIL rr_drain: got %b want 010", s_r_valid_o); else n_pass++;
        step();
        drive_idle();
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < MO; i++) begin
            drive_idle();
            s_req_i = 3'b001; m_gnt_i = 1'b1;
            @(negedge clk);
            step();
        end
        drive_idle();
        s_req_i = 3'b001; m_gnt_i = 1'b1; m_r_valid_i = 1'b1;
        @(negedge clk);
        n_total++; if (outstnd_o !== 3'd4) $display("FAIL full_count: got %0d want 4", outstnd_o); else n_pass++;
        n_total++; if (m_req_o !== 1'b0) $display("FAIL full_blocks_req: got %b want 0", m_req_o); else n_pass++;
        n_total++; if (s_gnt_o !== 3'b000) $display("FAIL full_no_gnt: got %b want 000", s_gnt_o); else n_pass++;
        n_total++; if (s_r_valid_o !== 3'b001) $display("FAIL full_pop_route: got %b want 001", s_r_valid_o); else n_pass++;
        step();
        drive_idle();
        s_req_i = 3'b001;
        @(negedge clk);
        n_total++; if (outstnd_o !== 3'd3) $display("FAIL full_after_pop: got %0d want 3", outstnd_o); else n_pass++;
        n_total++; if (m_req_o !== 1'b1) $display("FAIL full_reopen: got %b want 1", m_req_o); else n_pass++;
        step();
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            m_r_valid_i = 1'b1;
            @(negedge clk);
            step();
        end
        drive_idle();
        @(negedge clk);
        n_total++; if (outstnd_o !== 3'd0) $display("FAIL full_drained: got %0d want 0", outstnd_o); else n_pass++;
    endtask

    task automatic test_routing();
        apply_reset();
        drive_idle();
        s_req_i = 3'b010; s_id_i[1] = 5'd3; s_add_i[1] = 32'h1000_0004; s_wen_i[1] = 1'b1; m_gnt_i = 1'b1;
        @(negedge clk);
        n_total++; if (s_gnt_o !== 3'b010) $display("FAIL route_gnt1: got %b want 010", s_gnt_o); else n_pass++;
        n_total++; if ({m_wen_o, m_add_o, m_id_o} !== {1'b1, 32'h1000_0004, 5'd3})
            $display("FAIL route_payload1: got %b/%h/%0d want 1/10000004/3", m_wen_o, m_add_o, m_id_o); else n_pass++;
        step();
        drive_idle();
        s_req_i = 3'b001; s_id_i[0] = 5'd7; s_wdata_i[0] = 32'hDEAD_BEEF; s_be_i[0] = 4'hA; m_gnt_i = 1'b1;
        @(negedge clk);
        n_total++; if ({m_wen_o, m_wdata_o, m_be_o, m_id_o} !== {1'b0, 32'hDEAD_BEEF, 4'hA, 5'd7})
            $display("FAIL route_payload0: got %b/%h/%h/%0d want 0/deadbeef/a/7", m_wen_o, m_wdata_o, m_be_o, m_id_o); else n_pass++;
        step();
        drive_idle();
        m_r_valid_i = 1'b1; m_r_rdata_i = 32'hA5A5_A5A5; m_r_id_i = 5'd3;
        @(negedge clk);
        n_total++; if (s_r_valid_o !== 3'b010) $display("FAIL route_rv1: got %b want 010", s_r_valid_o); else n_pass++;
        n_total++; if ({s_r_rdata_o[1], s_r_id_o[1], s_r_rdata_o[0]} !== {32'hA5A5_A5A5, 5'd3, 32'h0})
            $display("FAIL route_data1: got %h/%0d other %h", s_r_rdata_o[1], s_r_id_o[1], s_r_rdata_o[0]); else n_pass++;
        step();
        drive_idle();
        m_r_valid_i = 1'b1; m_r_rdata_i = 32'h5A5A_5A5A; m_r_id_i = 5'd7;
        @(negedge clk);
        n_total++; if (s_r_valid_o !== 3'b001) $display("FAIL route_rv0: got %b want 001", s_r_valid_o); else n_pass++;
        n_total++; if ({s_r_rdata_o[0], s_r_id_o[0], s_r_rdata_o[1]} !== {32'h5A5A_5A5A, 5'd7, 32'h0})
            $display("FAIL route_data0: got %h/%0d other %h", s_r_rdata_o[0], s_r_id_o[0], s_r_rdata_o[1]); else n_pass++;
        step();
        drive_idle();
        s_add_i[2] = 32'hFFFF_0000; s_id_i[2] = 5'd9;
        @(negedge clk);
        n_total++; if ({m_req_o, m_add_o, m_id_o} !== '0)
            $display("FAIL idle_payload: got %b/%h/%0d want all zero", m_req_o, m_add_o, m_id_o); else n_pass++;
        n_total++; if (err_o !== 1'b0) $display("FAIL route_no_err: got %b want 0", err_o); else n_pass++;
        step();
    endtask

    task automatic test_err();
        apply_reset();
        drive_idle();
        m_r_valid_i = 1'b1; m_r_rdata_i = 32'hCAFE_F00D; m_r_id_i = 5'd1;
        @(negedge clk);
        n_total++; if (s_r_valid_o !== 3'b000) $display("FAIL err_dropped: got %b want 000", s_r_valid_o); else n_pass++;
        step();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if (err_o !== 1'b1) $display("FAIL err_sticky[%0d]: got %b want 1", i, err_o); else n_pass++;
            step();
        end
        rst_i = 1'b1;
        @(negedge clk);
        n_total++; if (err_o !== 1'b0) $display("FAIL err_cleared: got %b want 0", err_o); else n_pass++;
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_push_pop();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive_idle();
            s_req_i = 3'b011; m_gnt_i = 1'b1;
            @(negedge clk);
            step();
        end
        drive_idle();
        s_req_i = 3'b100; m_gnt_i = 1'b1; m_r_valid_i = 1'b1; m_r_rdata_i = 32'h0000_0001;
        @(negedge clk);
        n_total++; if (outstnd_o !== 3'd2) $display("FAIL pp_before: got %0d want 2", outstnd_o); else n_pass++;
        n_total++; if ({s_gnt_o, s_r_valid_o} !== {3'b100, 3'b001})
            $display("FAIL pp_gnt_route: got gnt %b rv %b want 100/001", s_gnt_o, s_r_valid_o); else n_pass++;
        step();
        drive_idle();
        @(negedge clk);
        n_total++; if (outstnd_o !== 3'd2) $display("FAIL pp_after: got %0d want 2", outstnd_o); else n_pass++;
        step();
        for (int i = 0; i < 2; i++) begin
            drive_idle();
            m_r_valid_i = 1'b1; m_r_rdata_i = $urandom;
            @(negedge clk);
            n_total++;
            if (s_r_valid_o !== 3'(2 << i)) $display("FAIL pp_order[%0d]: got %b want %b", i, s_r_valid_o, 3'(2 << i));
            else n_pass++;
            step();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            s_req_i = 3'b001; m_gnt_i = 1'b1;
            @(negedge clk);
            step();
        end
        drive_idle();
        @(negedge clk);
        n_total++; if (outstnd_o !== 3'd3) $display("FAIL mid_pre: got %0d want 3", outstnd_o); else n_pass++;
        step();
        rst_i = 1'b1;
        s_req_i = 3'b011; m_gnt_i = 1'b1; m_r_valid_i = 1'b1;
        @(negedge clk);
        n_total++; if ({outstnd_o, err_o} !== {3'd0, 1'b0})
            $display("FAIL mid_reset: got outstnd %0d err %b want 0/0", outstnd_o, err_o); else n_pass++;
        n_total++; if ({m_req_o, s_gnt_o, s_r_valid_o} !== '0)
            $display("FAIL mid_reset_outs: got req %b gnt %b rv %b want 0", m_req_o, s_gnt_o, s_r_valid_o); else n_pass++;
        step();
        rst_i = 1'b0;
        drive_idle();
        s_req_i = 3'b011; m_gnt_i = 1'b1;
        @(negedge clk);
        n_total++; if (s_gnt_o !== 3'b001) $display("FAIL mid_rr_zero: got %b want 001", s_gnt_o); else n_pass++;
        step();
        for (int i = 0; i < 2; i++) begin
            drive_idle();
            m_r_valid_i = 1'b1;
            @(negedge clk);
            n_total++;
            if (s_r_valid_o !== ((i == 0) ? 3'b001 : 3'b000))
                $display("FAIL mid_discard[%0d]: got %b", i, s_r_valid_o);
            else n_pass++;
            step();
        end
        drive_idle();
        @(negedge clk);
        n_total++; if (err_o !== 1'b1) $display("FAIL mid_err: got %b want 1", err_o); else n_pass++;
        step();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            int w;
            logic [NB-1:0]          e_rv;
            logic [NB-1:0][DW-1:0]  e_rd;
            logic [NB-1:0][IDW-1:0] e_id;
            s_req_i = NB'($urandom);
            s_wen_i = NB'($urandom);
            for (int p = 0; p < NB; p++) begin
                s_add_i[ix(p)]   = $urandom;
                s_wdata_i[ix(p)] = $urandom;
                s_be_i[ix(p)]    = BEW'($urandom);
                s_id_i[ix(p)]    = IDW'($urandom);
            end
            m_gnt_i     = ($urandom_range(3) != 0);
            m_r_valid_i = (mdl_q.size() > 0) ? ($urandom_range(1) == 1) : ($urandom_range(40) == 0);
            m_r_rdata_i = $urandom;
            m_r_id_i    = IDW'($urandom);
            @(negedge clk);
            w = mdl_winner();
            e_rv = '0; e_rd = '0; e_id = '0;
            if (m_r_valid_i && mdl_q.size() > 0) begin
                e_rv[ix(mdl_q[0])] = 1'b1;
                e_rd[ix(mdl_q[0])] = m_r_rdata_i;
                e_id[ix(mdl_q[0])] = m_r_id_i;
            end
            n_total++; if (m_req_o !== (w >= 0)) $display("FAIL rnd_req[%0d]: got %b want %b", c, m_req_o, w >= 0); else n_pass++;
            n_total++; if ({m_wen_o, m_add_o, m_wdata_o, m_be_o, m_id_o} !== mdl_payload(w))
                $display("FAIL rnd_payload[%0d]: got %h want %h", c, {m_wen_o, m_add_o, m_wdata_o, m_be_o, m_id_o}, mdl_payload(w));
            else n_pass++;
            n_total++; if (s_gnt_o !== ((w >= 0 && m_gnt_i) ? NB'(1 << w) : NB'(0)))
                $display("FAIL rnd_gnt[%0d]: got %b winner %0d", c, s_gnt_o, w); else n_pass++;
            n_total++; if ({s_r_valid_o, s_r_rdata_o, s_r_id_o} !== {e_rv, e_rd, e_id})
                $display("FAIL rnd_resp[%0d]: got rv %b data %h want rv %b data %h", c, s_r_valid_o, s_r_rdata_o, e_rv, e_rd);
            else n_pass++;
            n_total++; if ({outstnd_o, err_o} !== {CW'(mdl_q.size()), mdl_err})
                $display("FAIL rnd_state[%0d]: got outstnd %0d err %b want %0d/%b", c, outstnd_o, err_o, mdl_q.size(), mdl_err);
            else n_pass++;
            step();
        end
        drive_idle();
    endtask

    initial begin
        rst_i = 1'b1;
        drive_idle();
        mdl_reset();
        test_reset();
        test_round_robin();
        test_full();
        test_routing();
        test_err();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmac_ctrl_arb.md
DMAC_CTRL_ARB -- requirements
Module: dmac_ctrl_arb

Interface
REQ-001 Parameter NB_PORTS, default 2, number of control slave ports (1..16).
REQ-002 Parameter ADDR_WIDTH, default 32, control address width.
REQ-003 Parameter DATA_WIDTH, default 32, control data width; BE_WIDTH = DATA_WIDTH/8.
REQ-004 Parameter ID_WIDTH, default 5, transaction ID width.
REQ-005 Parameter MAX_OUTSTND, default 4, route-FIFO depth (power of 2, >=2).
REQ-006 clk_i  in  1  single clock, all state rising-edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 s_req_i / s_wen_i  in  NB_PORTS  per-port request / write-enable (1 = read).
REQ-009 s_add_i / s_wdata_i / s_be_i / s_id_i  in  NB_PORTS x ADDR_WIDTH / DATA_WIDTH / BE_WIDTH / ID_WIDTH  per-port payload.
REQ-010 s_gnt_o / s_r_valid_o  out  NB_PORTS  per-port grant / response valid.
REQ-011 s_r_rdata_o / s_r_id_o  out  NB_PORTS x DATA_WIDTH / ID_WIDTH  per-port response payload.
REQ-012 m_req_o, m_wen_o, m_add_o, m_wdata_o, m_be_o, m_id_o  out  1 / 1 / ADDR_WIDTH / DATA_WIDTH / BE_WIDTH / ID_WIDTH  request to DMA control target.
REQ-013 m_gnt_i, m_r_valid_i  in  1; m_r_rdata_i  in  DATA_WIDTH; m_r_id_i  in  ID_WIDTH  target grant/response.
REQ-014 outstnd_o  out  clog2(MAX_OUTSTND+1)  granted-but-unanswered count.
REQ-015 err_o  out  1  sticky: response received with empty route FIFO.

Function
REQ-016 Arbitration round-robin; search starts at pointer rr_q, first asserted s_req_i at or after rr_q (mod NB_PORTS) wins.
REQ-017 m_req_o = OR(s_req_i) AND NOT fifo_full; m_* payload = winner's payload, zero added latency; payload '0 when m_req_o low.
REQ-018 Grant: s_gnt_o[k] = m_gnt_i AND m_req_o AND (winner==k); at most one bit set.
REQ-019 On grant of port k: rr_q <= (k+1) mod NB_PORTS; push k into route FIFO; no grant -> rr_q unchanged.
REQ-020 Responses in order: m_r_valid_i pops FIFO head h; s_r_valid_o[h]=1, s_r_rdata_o[h]=m_r_rdata_i, s_r_id_o[h]=m_r_id_i, same cycle; other ports r_valid 0, rdata/r_id '0.
REQ-021 Full: fifo_full (registered count == MAX_OUTSTND) blocks m_req_o, even when a pop occurs that cycle.
REQ-022 Simultaneous push and pop when not full: count unchanged, both pointers advance.
REQ-023 m_r_valid_i with empty FIFO: response dropped, no s_r_valid_o, err_o set until reset.
REQ-024 Pointers wrap modulo MAX_OUTSTND; outstnd_o = registered count, 0..MAX_OUTSTND.
REQ-025 Requester may drop s_req_i before grant; arbiter re-evaluates every cycle, no lock.

Reset
REQ-026 rst_i asserted: rr_q=0, FIFO empty, outstnd_o=0, err_o=0, all s_gnt_o/s_r_valid_o/m_req_o 0 within the same cycle.
REQ-027 Reset mid-operation discards all pending routes; later responses hit REQ-023 only after reset release.

Structure
REQ-028 Shared package dmac_pkg holds the port-index type width function and the MAX_OUTSTND default constant.
REQ-029 Sub-module dmac_route_fifo (depth MAX_OUTSTND, width clog2(NB_PORTS)) with push/pop/full/empty/count.
REQ-030 Arbiter and response demux remain in dmac_ctrl_arb; no latches, no combinational path from m_r_valid_i to m_req_o.

Verification
REQ-031 Ports 0,1 request continuously, m_gnt_i=1 -> grants alternate 0,1,0,1; rr_q toggles each cycle.
REQ-032 4 grants with no response, MAX_OUTSTND=4 -> outstnd_o=4, m_req_o=0 next cycle; one response -> m_req_o=1 the following cycle.
REQ-033 Grants port1 (id 3) then port0 (id 7); responses rdata 0xA5A5A5A5 then 0x5A5A5A5A -> port1 gets 0xA5A5A5A5/id 3, port0 gets 0x5A5A5A5A/id 7.
REQ-034 m_r_valid_i=1 with outstnd_o=0 -> no s_r_valid_o, err_o=1 and held until rst_i.
REQ-035 Push and pop same cycle at outstnd_o=2 -> outstnd_o stays 2, routing correct.
REQ-036 rst_i pulsed with outstnd_o=3 -> outstnd_o=0, rr_q=0, err_o=0 immediately.
